// File: rtl/alu_issue.sv
// RV32I ALU-op decoder feeding a two-entry skid buffer; outputs are the final
// ALU operands/control, registered so the ALU sees no decode logic in its path.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_ctrl,
  output logic [4:0]  rd,
  output logic        illegal
);

  // state | meaning
  // EMPTY | nothing buffered, outputs invalid
  // ONE   | main register holds the output entry
  // TWO   | main register plus skid register full, input stalled
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  state_t      state;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        dec_ok;
  logic [4:0]  dec_op;
  logic [31:0] dec_a_raw;
  logic [31:0] dec_b_raw;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_ctrl;
  logic        dec_ill;
  logic [31:0] sk_a;
  logic [31:0] sk_b;
  logic [4:0]  sk_ctrl;
  logic [4:0]  sk_rd;
  logic        sk_ill;
  logic        accept;
  logic        drain;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    dec_ok    = 1'b0;
    dec_op    = OP_ADD;
    dec_a_raw = rs1_data;
    dec_b_raw = rs2_data;
    case (opcode)
      OPC_R: begin
        case (funct3)
          3'b000: begin
            dec_ok = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            dec_op = funct7[5] ? OP_SUB : OP_ADD;
          end
          3'b001: begin dec_ok = (funct7 == F7_ZERO); dec_op = OP_SLL;  end
          3'b010: begin dec_ok = (funct7 == F7_ZERO); dec_op = OP_SLT;  end
          3'b011: begin dec_ok = (funct7 == F7_ZERO); dec_op = OP_SLTU; end
          3'b100: begin dec_ok = (funct7 == F7_ZERO); dec_op = OP_XOR;  end
          3'b101: begin
            dec_ok = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            dec_op = funct7[5] ? OP_SRA : OP_SRL;
          end
          3'b110: begin dec_ok = (funct7 == F7_ZERO); dec_op = OP_OR;   end
          default: begin dec_ok = (funct7 == F7_ZERO); dec_op = OP_AND; end
        endcase
      end
      OPC_I: begin
        dec_b_raw = {{20{instr[31]}}, instr[31:20]};
        case (funct3)
          3'b000: begin dec_ok = 1'b1; dec_op = OP_ADD;  end
          3'b010: begin dec_ok = 1'b1; dec_op = OP_SLT;  end
          3'b011: begin dec_ok = 1'b1; dec_op = OP_SLTU; end
          3'b100: begin dec_ok = 1'b1; dec_op = OP_XOR;  end
          3'b110: begin dec_ok = 1'b1; dec_op = OP_OR;   end
          3'b111: begin dec_ok = 1'b1; dec_op = OP_AND;  end
          3'b001: begin
            dec_ok    = (funct7 == F7_ZERO);
            dec_op    = OP_SLL;
            dec_b_raw = {27'd0, instr[24:20]};
          end
          default: begin
            dec_ok    = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            dec_op    = funct7[5] ? OP_SRA : OP_SRL;
            dec_b_raw = {27'd0, instr[24:20]};
          end
        endcase
      end
      OPC_LUI: begin
        dec_ok    = 1'b1;
        dec_a_raw = 32'd0;
        dec_b_raw = {instr[31:12], 12'h000};
      end
      OPC_AUIPC: begin
        dec_ok    = 1'b1;
        dec_a_raw = pc;
        dec_b_raw = {instr[31:12], 12'h000};
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Illegal entries still flow through, but with zeroed operands and control.
  assign dec_ill  = ~dec_ok;
  assign dec_a    = dec_ok ? dec_a_raw : 32'd0;
  assign dec_b    = dec_ok ? dec_b_raw : 32'd0;
  assign dec_ctrl = dec_ok ? dec_op : OP_ADD;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      alu_a     <= 32'd0;
      alu_b     <= 32'd0;
      alu_ctrl  <= 5'd0;
      rd        <= 5'd0;
      illegal   <= 1'b0;
      sk_a      <= 32'd0;
      sk_b      <= 32'd0;
      sk_ctrl   <= 5'd0;
      sk_rd     <= 5'd0;
      sk_ill    <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            alu_a     <= dec_a;
            alu_b     <= dec_b;
            alu_ctrl  <= dec_ctrl;
            rd        <= instr[11:7];
            illegal   <= dec_ill;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            alu_a    <= dec_a;
            alu_b    <= dec_b;
            alu_ctrl <= dec_ctrl;
            rd       <= instr[11:7];
            illegal  <= dec_ill;
          end else if (accept) begin
            sk_a     <= dec_a;
            sk_b     <= dec_b;
            sk_ctrl  <= dec_ctrl;
            sk_rd    <= instr[11:7];
            sk_ill   <= dec_ill;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (drain) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (drain) begin
            alu_a    <= sk_a;
            alu_b    <= sk_b;
            alu_ctrl <= sk_ctrl;
            rd       <= sk_rd;
            illegal  <= sk_ill;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: expected entries are queued at accept and
// compared when the block presents them, including while held under stall.
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_ctrl;
  logic [4:0]  rd;
  logic        illegal;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .rd(rd),
    .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  ctrl;
    logic [4:0]  rd;
    logic        ill;
  } ent_t;

  ent_t q[$];
  ent_t pend;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [4:0] ec, input logic [4:0] er, input logic ei);
    in_valid  = 1'b1;
    instr     = i;
    pc        = p;
    rs1_data  = r1;
    rs2_data  = r2;
    pend.a    = ea;
    pend.b    = eb;
    pend.ctrl = ec;
    pend.rd   = er;
    pend.ill  = ei;
  endtask

  // Called just after a falling edge with inputs settled; advances one cycle.
  task automatic cycle();
    ent_t e;
    if (in_valid && in_ready && !flush) q.push_back(pend);
    if (out_valid && !flush) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {31'd0, out_valid}, 32'd0);
      end else begin
        e = q[0];
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("alu_ctrl", {27'd0, alu_ctrl}, {27'd0, e.ctrl});
        chk("rd", {27'd0, rd}, {27'd0, e.rd});
        chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
        if (out_ready) void'(q.pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    instr = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    pend = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_ctrl_rd_ill", {21'd0, alu_ctrl, rd, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // sub x10,x10,x11 accepted on the first edge after reset release
    out_ready = 1'b1;
    offer(32'h40B50533, 32'd0, 32'd7, 32'd9, 32'd7, 32'd9, 5'd1, 5'd10, 1'b0);
    cycle();
    chk("sub_latency_out_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    cycle();

    // back-to-back decode stream with continuous drain
    offer(32'hFFF00093, 32'd0, 32'h55, 32'd0, 32'h55, 32'hFFFFFFFF, 5'd0, 5'd1, 1'b0);
    cycle();
    offer(32'h40315093, 32'd0, 32'h80000000, 32'd0, 32'h80000000, 32'd3, 5'd7, 5'd1, 1'b0);
    cycle();
    offer(32'h12345097, 32'h100, 32'hDEAD, 32'd0, 32'h100, 32'h12345000, 5'd0, 5'd1, 1'b0);
    cycle();
    offer(32'hABCDE0B7, 32'h40, 32'h1111, 32'd0, 32'd0, 32'hABCDE000, 5'd0, 5'd1, 1'b0);
    cycle();
    offer(32'h40B55533, 32'd0, 32'hF0, 32'd4, 32'hF0, 32'd4, 5'd7, 5'd10, 1'b0);
    cycle();
    offer(32'h00B53533, 32'd0, 32'd1, 32'd2, 32'd1, 32'd2, 5'd9, 5'd10, 1'b0);
    cycle();
    offer(32'h0FF57513, 32'd0, 32'h1234, 32'd0, 32'h1234, 32'hFF, 5'd2, 5'd10, 1'b0);
    cycle();
    offer(32'h40B57533, 32'd0, 32'd5, 32'd6, 32'd0, 32'd0, 5'd0, 5'd10, 1'b1);
    cycle();
    offer(32'h0000007F, 32'h80, 32'd5, 32'd6, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    cycle();
    offer(32'h40109093, 32'd0, 32'd5, 32'd6, 32'd0, 32'd0, 5'd0, 5'd1, 1'b1);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("stream_drained", {31'd0, out_valid}, 32'd0);

    // backpressure: three offers, two accepted, outputs held
    out_ready = 1'b0;
    offer(32'h00B50533, 32'd0, 32'd1, 32'd2, 32'd1, 32'd2, 5'd0, 5'd10, 1'b0);
    cycle();
    offer(32'h00B54533, 32'd0, 32'd3, 32'd4, 32'd3, 32'd4, 5'd4, 5'd10, 1'b0);
    cycle();
    offer(32'h00B56533, 32'd0, 32'd5, 32'd6, 32'd5, 32'd6, 5'd3, 5'd10, 1'b0);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    cycle();
    cycle();
    chk("bp_queue_depth", q.size(), 32'd2);
    out_ready = 1'b1;
    cycle();
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("bp_all_out", q.size(), 32'd0);

    // flush while TWO with a simultaneous offer
    out_ready = 1'b0;
    offer(32'h00B50533, 32'd0, 32'd8, 32'd9, 32'd8, 32'd9, 5'd0, 5'd10, 1'b0);
    cycle();
    offer(32'h00B51533, 32'd0, 32'd8, 32'd9, 32'd8, 32'd9, 5'd5, 5'd10, 1'b0);
    cycle();
    chk("flush_pre_two", {31'd0, in_ready}, 32'd0);
    offer(32'h00B52533, 32'd0, 32'd8, 32'd9, 32'd8, 32'd9, 5'd8, 5'd10, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    q.delete();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("flush_nothing_emitted", {31'd0, out_valid}, 32'd0);

    // asynchronous reset while ONE
    out_ready = 1'b0;
    offer(32'h00B50533, 32'd0, 32'h77, 32'h88, 32'h77, 32'h88, 5'd0, 5'd10, 1'b0);
    cycle();
    in_valid = 1'b0;
    chk("arst_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_alu_a", alu_a, 32'd0);
    chk("arst_alu_b", alu_b, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    offer(32'h00B53533, 32'd0, 32'h3, 32'h4, 32'h3, 32'h4, 5'd9, 5'd10, 1'b0);
    cycle();
    chk("arst_first_accept", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;

    for (int k = 0; k < 10 && q.size() > 0; k++) cycle();
    chk("final_queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
